rpc_slot_queue: RTL and testbench

//  Slot-addressed request store for the NIC TX path: each pushed RPC is written into a free slot
//  and its slot id is returned; consumers later pop by slot id (read + free).
//  A circular free-list FIFO of slot ids allocates slots; per-slot busy bits catch misuse.

---
 rtl/rpc_slot_queue.sv | 122 ++++++++++++
 tb/tb_rpc_slot_queue.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rpc_slot_queue.sv
// Slot-addressed RPC store: a circular free list hands out slot ids on push, and pop frees them.
// Optional macro RQ_OCCUPANCY_EN adds occupancy_out, a registered count of busy slots.
module rpc_slot_queue #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned LSIZE      = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_en_in,
  input  logic [DATA_WIDTH-1:0] push_data_in,
  output logic [LSIZE-1:0]      push_slot_id_out,
  output logic                  push_done_out,
  input  logic                  pop_en_in,
  input  logic [LSIZE-1:0]      pop_slot_id_in,
  output logic [DATA_WIDTH-1:0] pop_data_out,
  input  logic                  initialize,
  output logic                  initialized,
  output logic                  error
`ifdef RQ_OCCUPANCY_EN
  ,
  output logic [LSIZE:0]        occupancy_out
`endif
);

  localparam int unsigned NSLOTS = 1 << LSIZE;
  localparam int unsigned CW     = LSIZE + 1;
  localparam logic [LSIZE-1:0] LastId = LSIZE'(NSLOTS - 1);

  typedef enum logic [1:0] {StIdle, StInit, StReady} state_e;

  state_e                state_q;
  logic [LSIZE-1:0]      free_list_q [NSLOTS];
  logic [DATA_WIDTH-1:0] mem_q       [NSLOTS];
  logic [LSIZE-1:0]      head_q, tail_q, init_cnt_q;
  logic [CW-1:0]         count_q;
  logic [NSLOTS-1:0]     busy_q;

  logic                  op_ok, push_ok, pop_ok, misuse, fl_we;
  logic [LSIZE-1:0]      push_id, fl_wdata;

  always_comb begin
    op_ok    = (state_q == StReady) && !initialize;
    // Uses the pre-pop count, so an id freed this cycle cannot serve a same-cycle push.
    push_ok  = op_ok && push_en_in && (count_q != '0);
    pop_ok   = op_ok && pop_en_in && busy_q[pop_slot_id_in];
    misuse   = (push_en_in && !push_ok) || (pop_en_in && !pop_ok);
    push_id  = free_list_q[head_q];
    fl_we    = ((state_q == StInit) && !initialize) || pop_ok;
    fl_wdata = (state_q == StInit) ? init_cnt_q : pop_slot_id_in;
  end

  // Storage arrays carry no reset; validity is tracked by count_q and busy_q.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[push_id] <= push_data_in;
    if (fl_we) free_list_q[tail_q] <= fl_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StIdle;
      head_q           <= '0;
      tail_q           <= '0;
      init_cnt_q       <= '0;
      count_q          <= '0;
      busy_q           <= '0;
      push_done_out    <= 1'b0;
      push_slot_id_out <= '0;
      pop_data_out     <= '0;
      initialized      <= 1'b0;
      error            <= 1'b0;
`ifdef RQ_OCCUPANCY_EN
      occupancy_out    <= '0;
`endif
    end else begin
      push_done_out <= 1'b0;
      if (misuse) error <= 1'b1;
      if (initialize) begin
        state_q     <= StInit;
        head_q      <= '0;
        tail_q      <= '0;
        init_cnt_q  <= '0;
        count_q     <= '0;
        busy_q      <= '0;
        initialized <= 1'b0;
`ifdef RQ_OCCUPANCY_EN
        occupancy_out <= '0;
`endif
      end else begin
        case (state_q)
          StInit: begin
            tail_q     <= tail_q + LSIZE'(1);
            count_q    <= count_q + CW'(1);
            init_cnt_q <= init_cnt_q + LSIZE'(1);
            if (init_cnt_q == LastId) begin
              state_q     <= StReady;
              initialized <= 1'b1;
            end
          end
          StReady: begin
            if (push_ok) begin
              busy_q[push_id]  <= 1'b1;
              head_q           <= head_q + LSIZE'(1);
              push_done_out    <= 1'b1;
              push_slot_id_out <= push_id;
            end
            if (pop_ok) begin
              busy_q[pop_slot_id_in] <= 1'b0;
              tail_q                 <= tail_q + LSIZE'(1);
              pop_data_out           <= mem_q[pop_slot_id_in];
            end
            count_q <= count_q + CW'(pop_ok) - CW'(push_ok);
`ifdef RQ_OCCUPANCY_EN
            occupancy_out <= occupancy_out + CW'(push_ok) - CW'(pop_ok);
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rpc_slot_queue.sv
// Directed self-checking bench for rpc_slot_queue (LSIZE=3, 32-bit payload).
module tb_rpc_slot_queue;

  localparam int unsigned DW = 32;
  localparam int unsigned LS = 3;

  logic          clk, reset_n;
  logic          push_en_in, pop_en_in, initialize;
  logic [DW-1:0] push_data_in, pop_data_out;
  logic [LS-1:0] push_slot_id_out, pop_slot_id_in;
  logic          push_done_out, initialized, error;
`ifdef RQ_OCCUPANCY_EN
  logic [LS:0]   occupancy_out;
`endif

  int checks   = 0;
  int failures = 0;

  rpc_slot_queue #(.DATA_WIDTH(DW), .LSIZE(LS)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .push_en_in       (push_en_in),
    .push_data_in     (push_data_in),
    .push_slot_id_out (push_slot_id_out),
    .push_done_out    (push_done_out),
    .pop_en_in        (pop_en_in),
    .pop_slot_id_in   (pop_slot_id_in),
    .pop_data_out     (pop_data_out),
    .initialize       (initialize),
    .initialized      (initialized),
    .error            (error)
`ifdef RQ_OCCUPANCY_EN
    ,
    .occupancy_out    (occupancy_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  // initialized rises exactly 8 cycles after initialize is sampled.
  task automatic do_init();
    initialize = 1'b1;
    step();
    initialize = 1'b0;
    chk("init_drop", 32'(initialized), 0);
    repeat (7) step();
    chk("init_early", 32'(initialized), 0);
    step();
    chk("init_done", 32'(initialized), 1);
  endtask

  task automatic push(input logic [DW-1:0] d);
    push_en_in   = 1'b1;
    push_data_in = d;
    step();
    push_en_in   = 1'b0;
  endtask

  task automatic pop(input logic [LS-1:0] id);
    pop_en_in      = 1'b1;
    pop_slot_id_in = id;
    step();
    pop_en_in      = 1'b0;
  endtask

  initial begin
    int exp_ids[6];
    exp_ids = '{3, 4, 5, 6, 7, 1};
    reset_n = 1'b0; push_en_in = 1'b0; pop_en_in = 1'b0; initialize = 1'b0;
    push_data_in = '0; pop_slot_id_in = '0;
    step();
    step();
    chk("rst_done", 32'(push_done_out), 0);
    chk("rst_id", 32'(push_slot_id_out), 0);
    chk("rst_pop_data", pop_data_out, 0);
    chk("rst_initialized", 32'(initialized), 0);
    chk("rst_error", 32'(error), 0);
    reset_n = 1'b1;
    step();

    do_init();
    chk("init_error", 32'(error), 0);

    // Back-to-back pushes A,B,C
    push_en_in = 1'b1;
    push_data_in = 32'hA000_000A; step();
    chk("push_a_done", 32'(push_done_out), 1);
    chk("push_a_id", 32'(push_slot_id_out), 0);
    push_data_in = 32'hB000_000B; step();
    chk("push_b_done", 32'(push_done_out), 1);
    chk("push_b_id", 32'(push_slot_id_out), 1);
    push_data_in = 32'hC000_000C; step();
    chk("push_c_done", 32'(push_done_out), 1);
    chk("push_c_id", 32'(push_slot_id_out), 2);
    push_en_in = 1'b0; step();
    chk("push_idle_done", 32'(push_done_out), 0);

    pop(3'd1);
    chk("pop_b_data", pop_data_out, 32'hB000_000B);
    step();
    chk("pop_b_hold", pop_data_out, 32'hB000_000B);

    // Freed id 1 comes back after the initial ids run out
    for (int k = 0; k < 6; k++) begin
      push(32'hD000_0000 + 32'(k));
      chk($sformatf("fill_done%0d", k), 32'(push_done_out), 1);
      chk($sformatf("fill_id%0d", k), 32'(push_slot_id_out), 32'(exp_ids[k]));
    end
    chk("full_no_error", 32'(error), 0);

    push(32'hEEEE_EEEE);
    chk("overflow_done", 32'(push_done_out), 0);
    chk("overflow_error", 32'(error), 1);
    step();
    chk("error_sticky", 32'(error), 1);

    // Double free of slot 5: data must not change and 5 must not be re-queued
    pop(3'd5);
    chk("pop5_data", pop_data_out, 32'hD000_0002);
    pop(3'd0);
    chk("pop0_data", pop_data_out, 32'hA000_000A);
    pop(3'd5);
    chk("dbl_free_hold", pop_data_out, 32'hA000_000A);
    push(32'h1111_1111);
    chk("realloc1_id", 32'(push_slot_id_out), 5);
    push(32'h2222_2222);
    chk("realloc2_id", 32'(push_slot_id_out), 0);
    push(32'h3333_3333);
    chk("realloc3_done", 32'(push_done_out), 0);

    // Re-init keeps the sticky error and restarts allocation at 0
    do_init();
    chk("reinit_error", 32'(error), 1);
    push(32'h4444_4444);
    chk("reinit_push_id", 32'(push_slot_id_out), 0);
    chk("reinit_push_done", 32'(push_done_out), 1);

    // Asynchronous reset clears error without a clock edge
    reset_n = 1'b0;
    #1;
    chk("async_rst_error", 32'(error), 0);
    step();
    reset_n = 1'b1;
    step();

    push(32'h5555_5555);
    chk("preinit_push_done", 32'(push_done_out), 0);
    chk("preinit_push_error", 32'(error), 1);

    do_reset();
    chk("rst2_error", 32'(error), 0);
    do_init();
    push(32'h6666_6666);
    push(32'h7777_7777);
    push(32'h8888_8888);
    pop(3'd0);
    chk("occ_pop_data", pop_data_out, 32'h6666_6666);
`ifdef RQ_OCCUPANCY_EN
    chk("occupancy", 32'(occupancy_out), 2);
`endif
    chk("pre_free_pop_error", 32'(error), 0);
    pop(3'd3);
    chk("free_pop_error", 32'(error), 1);
    chk("free_pop_hold", pop_data_out, 32'h6666_6666);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
